// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : wb_initiator
// Summary  : Pipelined Wishbone B4 master. It turns a valid/ready command stream
//            into bus cycles and returns one response per command, in order.
// Revision : 1.0  initial release
// ============================================================================
module wb_initiator #(
    parameter int ADDR_W    = 8,
    parameter int MAX_OUTST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_data_i,
    input  logic [3:0]        req_sel_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [31:0]       wb_data_o,
    output logic [3:0]        wb_sel_o,
    input  logic              wb_stall_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic [31:0]       wb_data_i,
    output logic              busy_o
);

    localparam int               c_wd_w      = $clog2(TIMEOUT + 1);
    localparam logic [3:0]       c_max_outst = 4'(MAX_OUTST);
    localparam logic [c_wd_w-1:0] c_timeout  = c_wd_w'(TIMEOUT);
    localparam logic [c_wd_w-1:0] c_wd_one   = c_wd_w'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ABORT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [c_wd_w-1:0]   wd_q, wd_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [3:0]          sel_q, sel_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_to_q, rsp_to_d;
    // Write flag of every outstanding command, oldest in bit 0.
    logic [15:0]         wefifo_q, wefifo_d;

    logic                w_accept;
    logic                w_complete;
    logic [3:0]          w_idx;

    assign req_ready_o = (state_q != S_ABORT) && (!stb_q || !wb_stall_i) && (cnt_q < c_max_outst);
    assign w_accept    = req_valid_i && req_ready_o;
    assign wb_cyc_o    = (cnt_q != 4'd0);
    assign w_complete  = wb_cyc_o && (wb_ack_i || wb_err_i);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 32'd0;
        rsp_err_d   = 1'b0;
        rsp_to_d    = 1'b0;
        wefifo_d    = wefifo_q;
        w_idx       = cnt_q;

        case ({w_accept, w_complete})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase

        if (w_complete) begin
            wefifo_d = wefifo_q >> 1;
            w_idx    = cnt_q - 4'd1;
        end
        if (w_accept) begin
            wefifo_d[w_idx] = req_we_i;
        end

        if (w_accept) begin
            stb_d  = 1'b1;
            we_d   = req_we_i;
            addr_d = req_addr_i;
            data_d = req_data_i;
            sel_d  = req_sel_i;
        end else if (stb_q && !wb_stall_i) begin
            stb_d = 1'b0;
        end

        if (w_complete) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = wb_err_i;
            if (wb_ack_i && !wb_err_i && !wefifo_q[0]) begin
                rsp_data_d = wb_data_i;
            end
        end

        if (state_q != S_ACTIVE || w_accept || w_complete) begin
            wd_d = '0;
        end else if (wd_q != c_timeout) begin
            wd_d = wd_q + c_wd_one;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // Watchdog expiry drops everything in flight and reports once.
                if (wd_d == c_timeout) begin
                    state_d     = S_ABORT;
                    cnt_d       = 4'd0;
                    stb_d       = 1'b0;
                    wefifo_d    = '0;
                    wd_d        = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'd0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                end else if (cnt_d == 4'd0) begin
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            wd_q        <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= 32'd0;
            sel_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            wefifo_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            wefifo_q    <= wefifo_d;
        end
    end

    assign wb_stb_o      = stb_q;
    assign wb_we_o       = we_q;
    assign wb_addr_o     = addr_q;
    assign wb_data_o     = data_q;
    assign wb_sel_o      = sel_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_to_q;
    assign busy_o        = (cnt_q != 4'd0) || (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_initiator
// Summary  : Self-checking bench: cycle-level transaction model plus scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_initiator;

    localparam int AW  = 8;
    localparam int MXO = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid_i, req_ready_o, req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [31:0]   req_data_i;
    logic [3:0]    req_sel_i;
    logic          rsp_valid_o, rsp_err_o, rsp_timeout_o;
    logic [31:0]   rsp_data_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [31:0]   wb_data_o;
    logic [3:0]    wb_sel_o;
    logic          wb_stall_i, wb_ack_i, wb_err_i;
    logic [31:0]   wb_data_i;
    logic          busy_o;

    always #5 clk = ~clk;

    wb_initiator #(.ADDR_W(AW), .MAX_OUTST(MXO), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_sel_i(req_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_data_i(wb_data_i), .busy_o(busy_o)
    );

    typedef struct { logic we; logic [AW-1:0] addr; logic [31:0] data; logic [3:0] sel; } cmd_t;
    typedef struct { logic we; int due; } pend_t;

    int checks = 0;
    int passes = 0;

    // Reference model: commands waiting for a strobe handshake, then waiting for ack/err.
    cmd_t  busq[$];
    pend_t pendq[$];
    logic  e_rv = 0, e_re = 0, e_rt = 0;
    logic [31:0] e_rd = 0;
    bit    m_abort = 0;
    int    m_idle = 0, cycn = 0, m_rsp = 0;

    bit    pv = 0;
    cmd_t  pc;
    int    n_todo = 0, gap_pct = 0, we_mode = 2, stall_pct = 0, stall_force = 0;
    int    lat_min = 1, lat_max = 1, err_pct = 0, both_pct = 0;
    bit    noack = 0, stray_req = 0, use_fixed = 0, fix_rd = 0;
    cmd_t  fixed_cmd;
    logic [31:0] fixed_rdata = 0;

    int    dut_rsp = 0, dut_hs = 0, stray_done = 0, ready_low_full = 0;
    int    last_acc_cyc = 0, last_rsp_cyc = 0, last_to_cyc = 0;
    logic [31:0] last_rsp_data = 0;
    logic  last_rsp_err = 0;

    task automatic cycle(input bit do_rst);
        logic  e_stb, e_rdy, st, ak, er, acc, comp;
        logic [31:0] drv;
        int    outst, r;
        pend_t p;
        cmd_t  c;
        outst = busq.size() + pendq.size();
        e_stb = !m_abort && (busq.size() != 0);

        checks++; if (rsp_valid_o !== e_rv) $display("FAIL rsp_valid cyc=%0d got %b exp %b", cycn, rsp_valid_o, e_rv); else passes++;
        if (e_rv) begin
            checks++;
            if ({rsp_data_o, rsp_err_o, rsp_timeout_o} !== {e_rd, e_re, e_rt})
                $display("FAIL rsp_fields cyc=%0d got %h/%b/%b exp %h/%b/%b", cycn, rsp_data_o, rsp_err_o, rsp_timeout_o, e_rd, e_re, e_rt);
            else passes++;
        end
        checks++; if (wb_stb_o !== e_stb) $display("FAIL stb cyc=%0d got %b exp %b", cycn, wb_stb_o, e_stb); else passes++;
        checks++; if (wb_cyc_o !== (outst != 0)) $display("FAIL cyc cyc=%0d got %b exp %b", cycn, wb_cyc_o, outst != 0); else passes++;
        checks++; if (busy_o !== (outst != 0 || m_abort)) $display("FAIL busy cyc=%0d got %b exp %b", cycn, busy_o, outst != 0 || m_abort); else passes++;
        if (e_stb) begin
            checks++;
            if ({wb_we_o, wb_addr_o, wb_data_o, wb_sel_o} !== {busq[0].we, busq[0].addr, busq[0].data, busq[0].sel})
                $display("FAIL bus_fields cyc=%0d got %b/%h/%h/%h exp %b/%h/%h/%h", cycn, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
                         busq[0].we, busq[0].addr, busq[0].data, busq[0].sel);
            else passes++;
        end
        if (rsp_valid_o === 1'b1) begin
            dut_rsp++;
            last_rsp_cyc  = cycn;
            last_rsp_data = rsp_data_o;
            last_rsp_err  = rsp_err_o;
            if (rsp_timeout_o === 1'b1) last_to_cyc = cycn;
        end

        // Slave behaviour for this cycle
        st = 1'b0; ak = 1'b0; er = 1'b0;
        if (stall_force > 0 && e_stb) begin
            st = 1'b1;
            stall_force--;
        end else begin
            st = ($urandom_range(99) < stall_pct);
        end
        drv = $urandom();
        if (!noack && pendq.size() != 0 && pendq[0].due <= cycn) begin
            r = $urandom_range(99);
            if (r < both_pct) begin ak = 1'b1; er = 1'b1; end
            else if (r < both_pct + err_pct) er = 1'b1;
            else ak = 1'b1;
            if (fix_rd) drv = fixed_rdata;
        end else if (stray_req && outst == 0) begin
            ak = 1'b1;
            stray_req = 0;
            stray_done++;
        end

        if (!pv && n_todo > 0 && $urandom_range(99) >= gap_pct) begin
            if (use_fixed) pc = fixed_cmd;
            else begin
                pc.we   = (we_mode == 2) ? 1'($urandom_range(1)) : (we_mode == 1);
                pc.addr = AW'($urandom());
                pc.data = $urandom();
                pc.sel  = 4'($urandom());
            end
            pv = 1;
            n_todo--;
        end

        rst_ni      = !do_rst;
        req_valid_i = pv;
        req_we_i    = pv ? pc.we : 1'($urandom_range(1));
        req_addr_i  = pv ? pc.addr : AW'($urandom());
        req_data_i  = pv ? pc.data : $urandom();
        req_sel_i   = pv ? pc.sel : 4'($urandom());
        wb_stall_i  = st;
        wb_ack_i    = ak;
        wb_err_i    = er;
        wb_data_i   = drv;
        #1;
        if (wb_stb_o === 1'b1 && !st) dut_hs++;
        e_rdy = !m_abort && (!e_stb || !st) && (outst < MXO);
        if (!do_rst) begin
            checks++; if (req_ready_o !== e_rdy) $display("FAIL ready cyc=%0d got %b exp %b", cycn, req_ready_o, e_rdy); else passes++;
            if (pv && req_ready_o === 1'b0 && outst == MXO) ready_low_full++;
        end

        if (do_rst) begin
            busq.delete(); pendq.delete();
            e_rv = 0; e_rd = 0; e_re = 0; e_rt = 0;
            m_abort = 0; m_idle = 0;
        end else begin
            acc  = pv && e_rdy;
            comp = (outst != 0) && (ak || er);
            e_rv = 0; e_rd = 0; e_re = 0; e_rt = 0;
            if (comp) begin
                p = pendq.pop_front();
                e_rv = 1; e_re = er;
                e_rd = (ak && !er && !p.we) ? drv : 32'd0;
                m_rsp++;
            end
            if (e_stb && !st) begin
                c = busq.pop_front();
                p.we  = c.we;
                p.due = cycn + $urandom_range(lat_max, lat_min);
                pendq.push_back(p);
            end
            if (acc) begin
                busq.push_back(pc);
                pv = 0;
                last_acc_cyc = cycn;
            end
            if (m_abort) begin
                m_abort = 0; m_idle = 0;
            end else if (outst == 0 || acc || comp) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_abort = 1; m_idle = 0;
                    busq.delete(); pendq.delete();
                    e_rv = 1; e_re = 1; e_rt = 1; e_rd = 0;
                    m_rsp++;
                end
            end
        end
        cycn++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int budget, input string name);
        int n = 0;
        while ((n_todo > 0 || pv || busq.size() != 0 || pendq.size() != 0 || e_rv || m_abort) && n < budget) begin
            cycle(0);
            n++;
        end
        checks++; if (n >= budget) $display("FAIL %s_drain got %0d cycles exp <%0d", name, n, budget); else passes++;
    endtask

    task automatic clean_slave();
        stall_pct = 0; stall_force = 0; lat_min = 1; lat_max = 1;
        err_pct = 0; both_pct = 0; noack = 0; fix_rd = 0; use_fixed = 0; gap_pct = 0;
    endtask

    task automatic test_reset();
        cycle(1);
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o} !== '0) $display("FAIL reset_bus got %b%b%b %h %h %h exp 0", wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o); else passes++;
        checks++; if ({rsp_valid_o, rsp_data_o, rsp_err_o, rsp_timeout_o, busy_o} !== '0) $display("FAIL reset_rsp got %b %h %b %b %b exp 0", rsp_valid_o, rsp_data_o, rsp_err_o, rsp_timeout_o, busy_o); else passes++;
    endtask

    task automatic test_single_write();
        int r0 = dut_rsp;
        clean_slave();
        use_fixed = 1;
        fixed_cmd.we = 1; fixed_cmd.addr = 8'h02; fixed_cmd.data = 32'hDEADBEEF; fixed_cmd.sel = 4'hF;
        n_todo = 1;
        run(50, "write");
        checks++; if (dut_rsp - r0 !== 1) $display("FAIL write_rsp_count got %0d exp 1", dut_rsp - r0); else passes++;
        checks++; if (last_rsp_cyc - last_acc_cyc !== 3) $display("FAIL write_latency got %0d exp 3", last_rsp_cyc - last_acc_cyc); else passes++;
        checks++; if ({last_rsp_err, last_rsp_data} !== 33'd0) $display("FAIL write_rsp got %b/%h exp 0/0", last_rsp_err, last_rsp_data); else passes++;
    endtask

    task automatic test_stalled_read();
        clean_slave();
        use_fixed = 1; fix_rd = 1; fixed_rdata = 32'h12345678; stall_force = 3;
        fixed_cmd.we = 0; fixed_cmd.addr = 8'h05; fixed_cmd.data = 32'h0; fixed_cmd.sel = 4'hF;
        n_todo = 1;
        run(50, "stall_read");
        checks++; if (last_rsp_data !== 32'h12345678) $display("FAIL stall_read_data got %h exp 12345678", last_rsp_data); else passes++;
        checks++; if (last_rsp_cyc - last_acc_cyc !== 6) $display("FAIL stall_read_latency got %0d exp 6", last_rsp_cyc - last_acc_cyc); else passes++;
    endtask

    task automatic test_back_to_back();
        int r0 = dut_rsp;
        int h0 = dut_hs;
        clean_slave();
        lat_min = 4; lat_max = 4; we_mode = 0; ready_low_full = 0;
        n_todo = 6;
        run(100, "b2b");
        checks++; if (dut_rsp - r0 !== 6) $display("FAIL b2b_rsp_count got %0d exp 6", dut_rsp - r0); else passes++;
        checks++; if (dut_hs - h0 !== 6) $display("FAIL b2b_strobes got %0d exp 6", dut_hs - h0); else passes++;
        checks++; if (ready_low_full == 0) $display("FAIL b2b_ready_low_when_full got %0d cycles exp >0", ready_low_full); else passes++;
    endtask

    task automatic test_ack_err();
        int r0;
        clean_slave();
        both_pct = 100; we_mode = 0;
        n_todo = 1;
        run(50, "ack_err");
        checks++; if ({last_rsp_err, last_rsp_data} !== {1'b1, 32'd0}) $display("FAIL ack_err_rsp got %b/%h exp 1/0", last_rsp_err, last_rsp_data); else passes++;
        both_pct = 0;
        r0 = dut_rsp;
        stray_req = 1;
        repeat (4) cycle(0);
        checks++; if (dut_rsp - r0 !== 0 || stray_done == 0) $display("FAIL stray_ack got %0d rsp exp 0", dut_rsp - r0); else passes++;
    endtask

    task automatic test_timeout();
        int r0 = dut_rsp;
        clean_slave();
        noack = 1; we_mode = 0;
        n_todo = 1;
        run(60, "timeout");
        checks++; if (last_to_cyc - last_acc_cyc !== TMO + 1) $display("FAIL timeout_latency got %0d exp %0d", last_to_cyc - last_acc_cyc, TMO + 1); else passes++;
        checks++; if (dut_rsp - r0 !== 1) $display("FAIL timeout_rsp_count got %0d exp 1", dut_rsp - r0); else passes++;
        noack = 0;
        stray_req = 1;
        repeat (3) cycle(0);
        we_mode = 1;
        n_todo = 1;
        run(50, "after_timeout");
        checks++; if (dut_rsp - r0 !== 2) $display("FAIL after_timeout_rsp_count got %0d exp 2", dut_rsp - r0); else passes++;
    endtask

    task automatic test_reset_midflight();
        int r0;
        clean_slave();
        lat_min = 6; lat_max = 6; we_mode = 0;
        n_todo = 3;
        repeat (4) cycle(0);
        checks++; if (wb_cyc_o !== 1'b1) $display("FAIL midflight_setup cyc got %b exp 1", wb_cyc_o); else passes++;
        r0 = dut_rsp;
        cycle(1);
        checks++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, busy_o} !== 6'd0) $display("FAIL midflight_reset got %b%b%b%b%b%b exp 000000", wb_cyc_o, wb_stb_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, busy_o); else passes++;
        lat_min = 1; lat_max = 1;
        repeat (3) cycle(0);
        checks++; if (dut_rsp - r0 !== 0) $display("FAIL midflight_no_rsp got %0d exp 0", dut_rsp - r0); else passes++;
        n_todo = 1;
        run(50, "post_reset");
        checks++; if (dut_rsp - r0 !== 1) $display("FAIL post_reset_rsp got %0d exp 1", dut_rsp - r0); else passes++;
    endtask

    task automatic test_random();
        int r0 = dut_rsp;
        int m0 = m_rsp;
        clean_slave();
        gap_pct = 30; stall_pct = 25; lat_min = 1; lat_max = 3; err_pct = 10; both_pct = 5; we_mode = 2;
        n_todo = 200;
        run(4000, "random");
        checks++; if (dut_rsp - r0 !== m_rsp - m0) $display("FAIL random_rsp_count got %0d exp %0d", dut_rsp - r0, m_rsp - m0); else passes++;
    endtask

    initial begin
        rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_sel_i = '0;
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_write();
        test_stalled_read();
        test_back_to_back();
        test_ack_err();
        test_timeout();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
